// File: rtl/irq_trap_scheduler.sv
// Interrupt entry/exit sequencer for the 3-stage core: synchronises and latches interrupt edges,
// arbitrates by fixed priority, waits for a safe MW commit slot, then issues one trap to the CSR file.
module irq_trap_scheduler #(
  parameter int NUM_IRQ     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CAUSE_BASE  = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupt,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               global_ie,
  input  logic               commit_valid,
  input  logic               commit_is_br,
  input  logic               commit_is_mret,
  input  logic [31:0]        commit_pc,
  input  logic               trap_ack,
  output logic               trap_req,
  output logic               trap_flush,
  output logic [31:0]        trap_epc,
  output logic [31:0]        trap_cause,
  output logic               in_handler,
  output logic               ack_timeout
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TRAP,
    S_WAIT_ACK,
    S_HANDLER
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] sync_prev_q;
  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] pending_q, pending_clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    winner, id_q;
  logic [3:0]         cnt_q, cnt_d;
  logic               take_trap;
  logic               safe_slot;

  assign irq_edge  = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign eligible  = pending_q & irq_mask & {NUM_IRQ{global_ie}};
  assign safe_slot = commit_valid & ~commit_is_br & ~commit_is_mret;

  // Lowest set index wins: scan from the top so the last hit is the highest priority.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    take_trap   = 1'b0;
    ack_timeout = 1'b0;
    pending_clr = '0;
    unique case (state_q)
      S_IDLE: begin
        if (eligible != '0) state_d = S_ARM;
      end
      S_ARM: begin
        if (eligible == '0) begin
          state_d = S_IDLE;
        end else if (safe_slot) begin
          state_d   = S_TRAP;
          take_trap = 1'b1;
        end
      end
      S_TRAP: begin
        pending_clr[id_q] = 1'b1;
        cnt_d             = '0;
        state_d           = trap_ack ? S_HANDLER : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (trap_ack) begin
          state_d = S_HANDLER;
        end else if (cnt_q == 4'(ACK_TIMEOUT - 1)) begin
          // Abandon the trap; the claimed line is deliberately not re-pended.
          ack_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HANDLER: begin
        if (commit_valid && commit_is_mret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign trap_req   = (state_q == S_TRAP);
  assign trap_flush = (state_q == S_TRAP);
  assign in_handler = (state_q == S_HANDLER);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // reset is asynchronous, so outputs decoded from state drop in the same cycle reset rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      sync_prev_q <= '0;
      pending_q   <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      trap_epc    <= '0;
      trap_cause  <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], interrupt};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      // A new edge outranks the claim clear on the same line.
      pending_q   <= (pending_q & ~pending_clr) | irq_edge;
      cnt_q       <= cnt_d;
      if (take_trap) begin
        id_q       <= winner;
        trap_epc   <= commit_pc + 32'd4;
        trap_cause <= {1'b1, 31'(CAUSE_BASE + int'(winner))};
      end
    end
  end

endmodule

// File: tb/tb_irq_trap_scheduler.sv
// Directed bench for irq_trap_scheduler: expected traps are queued when stimulus is driven and
// popped by a monitor whenever the DUT raises trap_req.
module tb_irq_trap_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  interrupt;
  logic [1:0]  irq_mask;
  logic        global_ie;
  logic        commit_valid;
  logic        commit_is_br;
  logic        commit_is_mret;
  logic [31:0] commit_pc;
  logic        trap_ack;
  logic        trap_req;
  logic        trap_flush;
  logic [31:0] trap_epc;
  logic [31:0] trap_cause;
  logic        in_handler;
  logic        ack_timeout;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   trap_count = 0;

  irq_trap_scheduler #(
    .NUM_IRQ(2), .SYNC_STAGES(2), .CAUSE_BASE(16), .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .irq_mask(irq_mask),
    .global_ie(global_ie), .commit_valid(commit_valid), .commit_is_br(commit_is_br),
    .commit_is_mret(commit_is_mret), .commit_pc(commit_pc), .trap_ack(trap_ack),
    .trap_req(trap_req), .trap_flush(trap_flush), .trap_epc(trap_epc),
    .trap_cause(trap_cause), .in_handler(in_handler), .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every trap_req must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && trap_req === 1'b1) begin
      exp_t e;
      trap_count++;
      compared++;
      assert (sb.size() != 0)
      else begin
        mismatched++;
        $error("FAIL unexpected_trap: observed cause %0h epc %0h expected no trap",
               trap_cause, trap_epc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("trap_cause", 64'(trap_cause), 64'(e.cause));
        check("trap_epc", 64'(trap_epc), 64'(e.epc));
        check("trap_flush", 64'(trap_flush), 64'd1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int line, input logic [31:0] epc);
    exp_t e;
    e.cause = 32'h8000_0000 | 32'(16 + line);
    e.epc   = epc;
    sb.push_back(e);
  endtask

  // Returns at the negedge inside the TRAP cycle; a missing trap counts as one failed comparison.
  task automatic wait_trap(input string tag);
    int n;
    n = 0;
    while (trap_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (trap_req !== 1'b1) check(tag, 64'd0, 64'd1);
  endtask

  task automatic ack_next_cycle();
    step(1);
    trap_ack = 1'b1;
    step(1);
    trap_ack = 1'b0;
  endtask

  task automatic mret_pulse();
    step(1);
    commit_is_mret = 1'b1;
    step(1);
    commit_is_mret = 1'b0;
  endtask

  task automatic expect_no_trap(input string tag, input int cycles);
    int c0;
    c0 = trap_count;
    repeat (cycles) @(negedge clk);
    check(tag, 64'(trap_count), 64'(c0));
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    interrupt      = 2'b00;
    irq_mask       = 2'b11;
    global_ie      = 1'b1;
    commit_valid   = 1'b0;
    commit_is_br   = 1'b0;
    commit_is_mret = 1'b0;
    commit_pc      = 32'h0;
    trap_ack       = 1'b0;

    @(negedge clk);
    check("reset_outputs", {58'd0, trap_req, trap_flush, in_handler, ack_timeout, 2'b00}, 64'd0);
    check("reset_epc_cause", {trap_epc, trap_cause}, 64'd0);
    step(2);
    reset = 1'b0;

    // Single line, steady non-branch commits.
    commit_valid = 1'b1;
    commit_pc    = 32'h100;
    push_exp(0, 32'h104);
    interrupt = 2'b01;
    wait_trap("t1_trap");
    ack_next_cycle();
    @(negedge clk);
    check("t1_in_handler", 64'(in_handler), 64'd1);
    interrupt = 2'b00;
    mret_pulse();
    @(negedge clk);
    check("t1_after_mret", 64'(in_handler), 64'd0);
    check("t1_epc_held", 64'(trap_epc), 64'h104);
    expect_no_trap("t1_no_retrap", 10);

    // Simultaneous edges: line 0 first, line 1 after mret with no new edge.
    commit_pc = 32'h300;
    push_exp(0, 32'h304);
    interrupt = 2'b11;
    wait_trap("t2_trap0");
    ack_next_cycle();
    push_exp(1, 32'h304);
    mret_pulse();
    wait_trap("t2_trap1");
    ack_next_cycle();
    interrupt = 2'b00;
    mret_pulse();
    expect_no_trap("t2_quiet", 8);

    // Branch commits are not a safe slot; then epc wrap-around.
    commit_pc    = 32'h200;
    commit_is_br = 1'b1;
    interrupt    = 2'b01;
    expect_no_trap("t3_branch_hold", 10);
    push_exp(0, 32'h204);
    step(1);
    commit_is_br = 1'b0;
    wait_trap("t3_trap");
    ack_next_cycle();
    interrupt = 2'b00;
    mret_pulse();
    step(4);
    commit_pc = 32'hFFFF_FFFC;
    push_exp(0, 32'h0);
    interrupt = 2'b01;
    wait_trap("t3_wrap_trap");
    ack_next_cycle();
    interrupt = 2'b00;
    mret_pulse();
    step(4);

    // Masked line stays pending and is taken once enabled.
    commit_pc = 32'h600;
    irq_mask  = 2'b10;
    interrupt = 2'b01;
    expect_no_trap("t_mask_hold", 10);
    push_exp(0, 32'h604);
    step(1);
    irq_mask = 2'b11;
    wait_trap("t_mask_trap");
    ack_next_cycle();
    interrupt = 2'b00;
    mret_pulse();
    step(4);

    // No acknowledge: timeout on the 15th WAIT_ACK cycle, back to IDLE, claim not restored.
    commit_pc = 32'h400;
    push_exp(0, 32'h404);
    interrupt = 2'b01;
    wait_trap("t4_trap");
    n = 0;
    while (ack_timeout !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_cycle", 64'(n), 64'd15);
    @(negedge clk);
    check("t4_pulse_once", 64'(ack_timeout), 64'd0);
    check("t4_not_handler", 64'(in_handler), 64'd0);
    expect_no_trap("t4_not_repended", 10);
    interrupt = 2'b00;
    step(4);

    // Edge during HANDLER waits for mret.
    commit_pc = 32'h500;
    push_exp(0, 32'h504);
    interrupt = 2'b01;
    wait_trap("t5_trap0");
    ack_next_cycle();
    interrupt = 2'b11;
    expect_no_trap("t5_nesting_blocked", 10);
    check("t5_still_handler", 64'(in_handler), 64'd1);
    push_exp(1, 32'h504);
    mret_pulse();
    wait_trap("t5_trap1");
    ack_next_cycle();
    interrupt = 2'b00;
    mret_pulse();
    step(4);

    // Reset in WAIT_ACK.
    commit_pc = 32'h700;
    push_exp(0, 32'h704);
    interrupt = 2'b01;
    wait_trap("t6_trap");
    step(1);
    reset = 1'b1;
    #1;
    check("t6_wait_outputs", {60'd0, trap_req, trap_flush, in_handler, ack_timeout}, 64'd0);
    check("t6_wait_epc_cause", {trap_epc, trap_cause}, 64'd0);
    interrupt = 2'b00;
    step(3);
    reset = 1'b0;
    expect_no_trap("t6_wait_no_trap", 10);

    // Reset in ARM (no commit slot available).
    commit_valid = 1'b0;
    interrupt    = 2'b01;
    step(8);
    reset = 1'b1;
    #1;
    check("t6_arm_outputs", {60'd0, trap_req, trap_flush, in_handler, ack_timeout}, 64'd0);
    interrupt = 2'b00;
    step(3);
    reset        = 1'b0;
    commit_valid = 1'b1;
    expect_no_trap("t6_arm_pending_cleared", 12);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
